pe_cmd_sequencer: RTL and testbench
===================================

# pe_cmd_sequencer

Byte-stream command front end for the cell processor array. Consumes command bytes from the serial receiver, decodes write, read, step and clear requests, and drives the array's `cmd`/`adr_x_i`/`adr_y_i`/`state_in` inputs with a hold-until-`written` handshake. Returns read data as bytes on a transmit stream. It sits directly upstream of the top-level array wrapper and replaces the raw switch-driven opcode and address inputs.

## Interface
- `N_COLS`, default `2**N_PX_BITS`: columns scanned by clear.
- `N_ROWS`, default `2**N_PY_BITS`: rows scanned by clear.
- `CMD_NOP`, default 0: array idle opcode.
- `CMD_WRITE`, default 1: array cell write opcode.
- `CMD_READ`, default 2: array cell read opcode.
- `CMD_STEP`, default 3: array one-generation opcode.
- `TIMEOUT_CYCLES`, default 1024: ack timeout; used only with the timeout macro.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `rx_data` in 8: command byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: byte accepted when `rx_valid && rx_ready`.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: response pending.
- `tx_ready` in 1: response consumed when `tx_valid && tx_ready`.
- `pe_cmd` out `PE_CMD_BITS`: opcode to array.
- `pe_adr_x` out `N_PX_BITS`: cell column.
- `pe_adr_y` out `N_PY_BITS`: cell row.
- `pe_state_wr` out `PE_STATE_BITS`: write data to array.
- `pe_state_rd` in `PE_STATE_BITS`: read data from array.
- `pe_written` in 1: array completion ack.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: sticky error; cleared only by `rst`.

## Operation
- Frames: `0x57` x y s = write; `0x52` x y = read; `0x53` n = step n generations; `0x43` = clear all cells.
- Other opcode bytes in IDLE: discarded, `err` set, stay IDLE.
- Argument bytes: low `N_PX_BITS`/`N_PY_BITS`/`PE_STATE_BITS` bits are used; upper bits are ignored.
- States:
  - IDLE → GET_X (W/R), GET_N (S), CLEAR (C).
  - GET_X → GET_Y → GET_S (W) or EXEC (R).
  - GET_S → EXEC.
  - GET_N: n=0 → IDLE with no array activity; otherwise EXEC with step counter = n.
  - EXEC: `pe_cmd` held non-NOP and address/data held stable until `pe_written` is sampled high. Then:
    - Read: capture `pe_state_rd` zero-extended to 8 bits, go to RESP.
    - Step: decrement counter; if nonzero, return to EXEC through one NOP cycle, else IDLE.
    - Write: go to IDLE.
  - RESP: `tx_valid` high with `tx_data` stable until `tx_ready`, then IDLE.
  - CLEAR: write 0 to every cell, y outer and x inner, from (0,0) to (`N_COLS`-1,`N_ROWS`-1). Each write uses the EXEC handshake. Return to IDLE after the last cell is acked.
- `rx_ready` is high only in IDLE, GET_X, GET_Y, GET_S and GET_N. Bytes are never dropped while busy.

## Timing
- Reset outputs: `pe_cmd`=`CMD_NOP`; `pe_adr_x`, `pe_adr_y`, `pe_state_wr`, `tx_data` all 0; `tx_valid`, `busy`, `err` 0; `rx_ready` 1.
- All outputs are registered.
- Latency: the cycle after the last frame byte is accepted, `pe_cmd` is driven.
- The cycle after `pe_written` is sampled high, `pe_cmd`=`CMD_NOP`. There is at least one NOP cycle between consecutive array commands.
- `pe_written` is ignored outside EXEC.
- Read: `tx_valid` rises the cycle after the ack.
- `rst` asserted mid-frame or mid-EXEC: next edge forces IDLE and reset values; any partial frame is discarded.
- `tx_ready` held high in RESP: the byte leaves in 1 cycle.

## Configuration
- `PE_SEQ_TIMEOUT_EN` defined:
  - EXEC counts cycles.
  - If `TIMEOUT_CYCLES` cycles pass without `pe_written`: `pe_cmd`→NOP, `err` set.
  - A read then sends `0xEE` via RESP.
  - Step or clear aborts the remaining work and goes to IDLE.
- `PE_SEQ_TIMEOUT_EN` undefined: EXEC waits indefinitely; no counter logic is present.

## Test plan
- Write: send `57 03 05 01`, ack `pe_written` 2 cycles after `pe_cmd`=1 → one WRITE with x=3, y=5, data=1, then NOP; `busy` falls after the ack.
- Read with backpressure: send `52 03 05`, `pe_state_rd`=1 at ack, `tx_ready` low 4 cycles → `tx_data`=`0x01` held stable, `tx_valid` high until `tx_ready`.
- Step: send `53 03` → exactly 3 STEP commands, each separated by ≥1 NOP; `53 00` → no array command.
- Clear: `43` on a 4×2 configuration → 8 WRITEs with data 0 in order (0,0)…(3,0),(0,1)…(3,1); `rx_ready` low throughout.
- Errors and reset: byte `0x41` → `err`=1, state IDLE. `rst` asserted during GET_Y → all reset values; the next `57 …` frame decodes correctly.
- Timeout (`PE_SEQ_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=16): read with no ack → `tx_data`=`0xEE` after 16 cycles, `err`=1.

Source files
------------

// File: rtl/pe_cmd_sequencer_if.sv
// Byte-stream and array-side signals of the command sequencer; slave = sequencer, master = environment.
// Zero latency (wires only); flow control is carried by the valid/ready pairs and the pe_written ack.
interface pe_cmd_sequencer_if #(
    parameter int N_PX_BITS     = 2,
    parameter int N_PY_BITS     = 3,
    parameter int PE_STATE_BITS = 1,
    parameter int PE_CMD_BITS   = 2
);
    logic [7:0]               rx_data;
    logic                     rx_valid;
    logic                     rx_ready;
    logic [7:0]               tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic [PE_CMD_BITS-1:0]   pe_cmd;
    logic [N_PX_BITS-1:0]     pe_adr_x;
    logic [N_PY_BITS-1:0]     pe_adr_y;
    logic [PE_STATE_BITS-1:0] pe_state_wr;
    logic [PE_STATE_BITS-1:0] pe_state_rd;
    logic                     pe_written;

    modport slave (
        input  rx_data, rx_valid, tx_ready, pe_state_rd, pe_written,
        output rx_ready, tx_data, tx_valid, pe_cmd, pe_adr_x, pe_adr_y, pe_state_wr
    );

    modport master (
        output rx_data, rx_valid, tx_ready, pe_state_rd, pe_written,
        input  rx_ready, tx_data, tx_valid, pe_cmd, pe_adr_x, pe_adr_y, pe_state_wr
    );
endinterface

// File: rtl/pe_cmd_sequencer.sv
// Decodes W/R/S/C byte frames into held array commands; read data returned as one tx byte.
// pe_cmd driven 1 cycle after the last frame byte; rx stalls (rx_ready low) while executing; optional ack timeout via PE_SEQ_TIMEOUT_EN.
module pe_cmd_sequencer #(
    parameter int N_PX_BITS      = 2,
    parameter int N_PY_BITS      = 3,
    parameter int PE_STATE_BITS  = 1,
    parameter int PE_CMD_BITS    = 2,
    parameter int N_COLS         = 2**N_PX_BITS,
    parameter int N_ROWS         = 2**N_PY_BITS,
    parameter int CMD_NOP        = 0,
    parameter int CMD_WRITE      = 1,
    parameter int CMD_READ       = 2,
    parameter int CMD_STEP       = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    pe_cmd_sequencer_if.slave  bus,
    output logic               busy,
    output logic               err
);

    localparam logic [PE_CMD_BITS-1:0] C_NOP   = PE_CMD_BITS'(CMD_NOP);
    localparam logic [PE_CMD_BITS-1:0] C_WRITE = PE_CMD_BITS'(CMD_WRITE);
    localparam logic [PE_CMD_BITS-1:0] C_READ  = PE_CMD_BITS'(CMD_READ);
    localparam logic [PE_CMD_BITS-1:0] C_STEP  = PE_CMD_BITS'(CMD_STEP);
    localparam logic [N_PX_BITS-1:0]   X_LAST  = N_PX_BITS'(N_COLS - 1);
    localparam logic [N_PY_BITS-1:0]   Y_LAST  = N_PY_BITS'(N_ROWS - 1);

    if (TIMEOUT_CYCLES < 1 || N_COLS < 1 || N_ROWS < 1 ||
        N_COLS > 2**N_PX_BITS || N_ROWS > 2**N_PY_BITS) begin : g_bad_cfg
        $error("pe_cmd_sequencer: invalid geometry or timeout parameters");
    end

    // Bit 4 is rx_ready and bit 3 is busy, so both outputs come straight off state flops.
    typedef enum logic [4:0] {
        S_IDLE  = 5'b10_000,
        S_GET_X = 5'b11_001,
        S_GET_Y = 5'b11_010,
        S_GET_S = 5'b11_011,
        S_GET_N = 5'b11_100,
        S_EXEC  = 5'b01_000,
        S_GAP   = 5'b01_001,
        S_RESP  = 5'b01_010,
        S_CLEAR = 5'b01_011
    } state_t;

    typedef enum logic [1:0] {OP_WR, OP_RD, OP_STEP, OP_CLR} op_t;

    state_t                   state_q;
    op_t                      op_q;
    logic [PE_CMD_BITS-1:0]   cmd_q;
    logic [N_PX_BITS-1:0]     adr_x_q;
    logic [N_PY_BITS-1:0]     adr_y_q;
    logic [PE_STATE_BITS-1:0] wr_q;
    logic [7:0]               tx_data_q;
    logic                     tx_valid_q;
    logic                     err_q;
    logic [7:0]               cnt_q;
`ifdef PE_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q;
`endif

    assign bus.rx_ready    = state_q[4];
    assign busy            = state_q[3];
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.pe_cmd      = cmd_q;
    assign bus.pe_adr_x    = adr_x_q;
    assign bus.pe_adr_y    = adr_y_q;
    assign bus.pe_state_wr = wr_q;
    assign err             = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_WR;
            cmd_q      <= C_NOP;
            adr_x_q    <= '0;
            adr_y_q    <= '0;
            wr_q       <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
`ifdef PE_SEQ_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
`ifdef PE_SEQ_TIMEOUT_EN
            tmo_q <= (state_q == S_EXEC) ? tmo_q + 1'b1 : '0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (bus.rx_valid) begin
                        case (bus.rx_data)
                            8'h57: begin op_q <= OP_WR;   state_q <= S_GET_X; end
                            8'h52: begin op_q <= OP_RD;   state_q <= S_GET_X; end
                            8'h53: begin op_q <= OP_STEP; state_q <= S_GET_N; end
                            8'h43: begin
                                op_q    <= OP_CLR;
                                adr_x_q <= '0;
                                adr_y_q <= '0;
                                wr_q    <= '0;
                                cmd_q   <= C_WRITE;
                                state_q <= S_EXEC;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                S_GET_X: begin
                    if (bus.rx_valid) begin
                        adr_x_q <= bus.rx_data[N_PX_BITS-1:0];
                        state_q <= S_GET_Y;
                    end
                end
                S_GET_Y: begin
                    if (bus.rx_valid) begin
                        adr_y_q <= bus.rx_data[N_PY_BITS-1:0];
                        if (op_q == OP_WR) begin
                            state_q <= S_GET_S;
                        end else begin
                            cmd_q   <= C_READ;
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_GET_S: begin
                    if (bus.rx_valid) begin
                        wr_q    <= bus.rx_data[PE_STATE_BITS-1:0];
                        cmd_q   <= C_WRITE;
                        state_q <= S_EXEC;
                    end
                end
                S_GET_N: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == 8'd0) begin
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q   <= bus.rx_data;
                            cmd_q   <= C_STEP;
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (bus.pe_written) begin
                        cmd_q <= C_NOP;
                        case (op_q)
                            OP_RD: begin
                                tx_data_q  <= 8'(bus.pe_state_rd);
                                tx_valid_q <= 1'b1;
                                state_q    <= S_RESP;
                            end
                            OP_STEP: begin
                                if (cnt_q == 8'd1) begin
                                    state_q <= S_IDLE;
                                end else begin
                                    cnt_q   <= cnt_q - 8'd1;
                                    state_q <= S_GAP;
                                end
                            end
                            OP_CLR: begin
                                // Row-major sweep: x inner, y outer; stop after the last cell's ack.
                                if (adr_x_q == X_LAST) begin
                                    if (adr_y_q == Y_LAST) begin
                                        state_q <= S_IDLE;
                                    end else begin
                                        adr_x_q <= '0;
                                        adr_y_q <= adr_y_q + 1'b1;
                                        state_q <= S_CLEAR;
                                    end
                                end else begin
                                    adr_x_q <= adr_x_q + 1'b1;
                                    state_q <= S_CLEAR;
                                end
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end
`ifdef PE_SEQ_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        cmd_q <= C_NOP;
                        err_q <= 1'b1;
                        if (op_q == OP_RD) begin
                            tx_data_q  <= 8'hEE;
                            tx_valid_q <= 1'b1;
                            state_q    <= S_RESP;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
`endif
                end
                S_GAP: begin
                    cmd_q   <= C_STEP;
                    state_q <= S_EXEC;
                end
                S_CLEAR: begin
                    cmd_q   <= C_WRITE;
                    state_q <= S_EXEC;
                end
                S_RESP: begin
                    if (bus.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_cmd_sequencer.sv
// Scoreboarded bench: expected array commands and tx bytes are queued as frames are sent
// and popped by monitors when the DUT issues a command or hands off a response byte.
module tb_pe_cmd_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic err;

    pe_cmd_sequencer_if #(.N_PX_BITS(2), .N_PY_BITS(3), .PE_STATE_BITS(1), .PE_CMD_BITS(2)) bus();

    pe_cmd_sequencer #(
        .N_PX_BITS(2), .N_PY_BITS(3), .PE_STATE_BITS(1), .PE_CMD_BITS(2),
        .N_COLS(4), .N_ROWS(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cmd;
        logic [1:0] x;
        logic [2:0] y;
        logic       d;
        bit         chk_adr;
        bit         chk_d;
    } exp_t;

    exp_t       exp_cmd_q[$];
    logic [7:0] exp_tx_q[$];
    int         checks   = 0;
    int         failures = 0;
    bit         ack_en   = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_cmd(input logic [1:0] c, input logic [1:0] x, input logic [2:0] y,
                            input logic d, input bit ca, input bit cd);
        exp_t e;
        e.cmd = c; e.x = x; e.y = y; e.d = d; e.chk_adr = ca; e.chk_d = cd;
        exp_cmd_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("rx_accept", bus.rx_ready, 1);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cmd"},  bus.pe_cmd, 0);
        chk({tag, "_x"},    bus.pe_adr_x, 0);
        chk({tag, "_y"},    bus.pe_adr_y, 0);
        chk({tag, "_wr"},   bus.pe_state_wr, 0);
        chk({tag, "_txd"},  bus.tx_data, 0);
        chk({tag, "_txv"},  bus.tx_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"},  err, 0);
        chk({tag, "_rxr"},  bus.rx_ready, 1);
    endtask

    // Array model: ack one cycle after noticing a held command, pulse pe_written for one cycle.
    initial begin : ack_model
        int w;
        w = 0;
        bus.pe_written = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.pe_written) begin
                bus.pe_written = 1'b0;
                w = 0;
            end else if (ack_en && bus.pe_cmd != 2'd0) begin
                if (w == 1) bus.pe_written = 1'b1;
                else w++;
            end else begin
                w = 0;
            end
        end
    end

    initial begin : monitor
        logic [1:0] prev_cmd;
        logic [1:0] hx;
        logic [2:0] hy;
        logic       txh;
        logic [7:0] txp;
        exp_t       e;
        prev_cmd = 2'd0; hx = '0; hy = '0; txh = 1'b0; txp = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.pe_cmd != 2'd0 && prev_cmd == 2'd0) begin
                    if (exp_cmd_q.size() == 0) begin
                        chk("unexp_cmd", bus.pe_cmd, 0);
                    end else begin
                        e = exp_cmd_q.pop_front();
                        chk("cmd", bus.pe_cmd, e.cmd);
                        if (e.chk_adr) begin
                            chk("cmd_x", bus.pe_adr_x, e.x);
                            chk("cmd_y", bus.pe_adr_y, e.y);
                        end
                        if (e.chk_d) chk("cmd_d", bus.pe_state_wr, e.d);
                    end
                    hx = bus.pe_adr_x;
                    hy = bus.pe_adr_y;
                end else if (bus.pe_cmd != 2'd0) begin
                    chk("hold_x", bus.pe_adr_x, hx);
                    chk("hold_y", bus.pe_adr_y, hy);
                end
                if (txh) chk("tx_stable", bus.tx_data, txp);
                if (bus.tx_valid && bus.tx_ready) begin
                    if (exp_tx_q.size() == 0) chk("unexp_tx", bus.tx_data, 32'hFFFF_FFFF);
                    else chk("tx_data", bus.tx_data, exp_tx_q.pop_front());
                end
                txh = bus.tx_valid && !bus.tx_ready;
                txp = bus.tx_data;
            end else begin
                txh = 1'b0;
            end
            prev_cmd = bus.pe_cmd;
        end
    end

    initial begin : stim
        int t;
        int viol;
        bus.rx_data     = 8'h00;
        bus.rx_valid    = 1'b0;
        bus.tx_ready    = 1'b0;
        bus.pe_state_rd = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst0");
        rst = 1'b0;

        // Write 57 03 05 01
        push_cmd(2'd1, 2'd3, 3'd5, 1'b1, 1'b1, 1'b1);
        send_byte(8'h57); send_byte(8'h03); send_byte(8'h05); send_byte(8'h01);
        chk("wr_latency", bus.pe_cmd, 1);
        chk("wr_busy", busy, 1);
        wait_idle("wr_idle");
        chk("wr_nop", bus.pe_cmd, 0);

        // Read 52 03 05 with tx backpressure
        bus.pe_state_rd = 1'b1;
        push_cmd(2'd2, 2'd3, 3'd5, 1'b0, 1'b1, 1'b0);
        exp_tx_q.push_back(8'h01);
        send_byte(8'h52); send_byte(8'h03); send_byte(8'h05);
        chk("rd_rxr_low", bus.rx_ready, 0);
        t = 0;
        while (!bus.tx_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("rd_txv", bus.tx_valid, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("rd_txv_held", bus.tx_valid, 1);
        chk("rd_busy_held", busy, 1);
        bus.tx_ready = 1'b1;
        @(posedge clk); #1;
        chk("rd_txv_drop", bus.tx_valid, 0);
        bus.tx_ready = 1'b0;
        wait_idle("rd_idle");

        // Step 3, then step 0
        repeat (3) push_cmd(2'd3, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        send_byte(8'h53); send_byte(8'h03);
        wait_idle("step_idle");
        chk("step_left", exp_cmd_q.size(), 0);
        send_byte(8'h53); send_byte(8'h00);
        chk("step0_busy", busy, 0);
        repeat (6) @(posedge clk);
        #1;

        // Clear on 4x2
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                push_cmd(2'd1, 2'(x), 3'(y), 1'b0, 1'b1, 1'b1);
        send_byte(8'h43);
        viol = 0;
        t = 0;
        while (busy && t < 500) begin
            if (bus.rx_ready) viol++;
            @(posedge clk); #1;
            t++;
        end
        chk("clr_idle", busy, 0);
        chk("clr_rxr_viol", viol, 0);
        chk("clr_left", exp_cmd_q.size(), 0);

        // Illegal opcode
        send_byte(8'h41);
        chk("bad_err", err, 1);
        chk("bad_busy", busy, 0);
        chk("bad_rxr", bus.rx_ready, 1);

        // Reset during GET_Y, then a frame with upper argument bits set
        send_byte(8'h57); send_byte(8'h03);
        chk("gety_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("rst1");
        rst = 1'b0;
        push_cmd(2'd1, 2'd2, 3'd2, 1'b1, 1'b1, 1'b1);
        send_byte(8'h57); send_byte(8'h06); send_byte(8'h0A); send_byte(8'h03);
        wait_idle("rst_wr_idle");

`ifdef PE_SEQ_TIMEOUT_EN
        ack_en = 1'b0;
        bus.tx_ready = 1'b1;
        push_cmd(2'd2, 2'd1, 3'd0, 1'b0, 1'b1, 1'b0);
        exp_tx_q.push_back(8'hEE);
        send_byte(8'h52); send_byte(8'h01); send_byte(8'h00);
        t = 0;
        while (!bus.tx_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("tmo_cycles", t, 16);
        chk("tmo_err", err, 1);
        chk("tmo_nop", bus.pe_cmd, 0);
        wait_idle("tmo_idle");
        bus.tx_ready = 1'b0;
        ack_en = 1'b1;
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("cmd_q_empty", exp_cmd_q.size(), 0);
        chk("tx_q_empty", exp_tx_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
